// File: rtl/cnn_pkg.sv
// Shared widths, writer state encoding and byte-enable constants for the CNN result writer.
`default_nettype none

package cnn_pkg;

   localparam int BUS_ADDR_WIDTH = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int BUS_DATA_WIDTH = 2 * DATA_WIDTH;
   localparam int BUS_WE_WIDTH   = BUS_DATA_WIDTH / 8;
   localparam int CNT_WIDTH      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } wr_state_e;

   localparam logic [BUS_WE_WIDTH-1:0] WE_FULL = 8'hFF;
   localparam logic [BUS_WE_WIDTH-1:0] WE_LO   = 8'h0F;

   // Byte address of bus word idx; the sum wraps modulo 2^BUS_ADDR_WIDTH.
   function automatic logic [BUS_ADDR_WIDTH-1:0] word_addr(
      input logic [BUS_ADDR_WIDTH-1:0] base,
      input logic [CNT_WIDTH-1:0]      idx
   );
      logic [BUS_ADDR_WIDTH-1:0] off;
      off = '0;
      off[CNT_WIDTH+2:3] = idx;
      return base + off;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_result_writer_if.sv
// Result stream (valid/ready) plus request/ack write bus seen by the result writer.
`default_nettype none

interface cnn_result_writer_if;
   import cnn_pkg::*;

   logic [DATA_WIDTH-1:0]     dataIn;
   logic                      validIn;
   logic                      readyOut;
   logic                      busReqOut;
   logic [BUS_ADDR_WIDTH-1:0] busAddrOut;
   logic [BUS_WE_WIDTH-1:0]   busWrEnOut;
   logic [BUS_DATA_WIDTH-1:0] busWrDataOut;
   logic                      busAckIn;

   modport master (
      input  dataIn, validIn, busAckIn,
      output readyOut, busReqOut, busAddrOut, busWrEnOut, busWrDataOut
   );

   modport slave (
      output dataIn, validIn, busAckIn,
      input  readyOut, busReqOut, busAddrOut, busWrEnOut, busWrDataOut
   );

endinterface

`default_nettype wire

// File: rtl/cnn_counter.sv
// Clearable up-counter; doneOut flags that the count equals endValIn.
`default_nettype none

module cnn_counter
   import cnn_pkg::*;
(
   input  wire logic                 clkIn,
   input  wire logic                 rstIn,
   input  wire logic                 clrIn,
   input  wire logic                 advIn,
   input  wire logic [CNT_WIDTH-1:0] endValIn,
   output logic      [CNT_WIDTH-1:0] cntOut,
   output logic                      doneOut
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clrIn) begin
         cnt_d = '0;
      end else if (advIn) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cntOut  = cnt_q;
   assign doneOut = (cnt_q == endValIn);

endmodule

`default_nettype wire

// File: rtl/cnn_result_writer.sv
// Drains 32-bit results, packs two per 64-bit word and writes them to consecutive bus addresses.
`default_nettype none

module cnn_result_writer
   import cnn_pkg::*;
(
   input  wire logic                      clkIn,
   input  wire logic                      rstIn,
   input  wire logic                      startIn,
   input  wire logic [BUS_ADDR_WIDTH-1:0] baseAddrIn,
   input  wire logic [CNT_WIDTH-1:0]      numResultsIn,
   cnn_result_writer_if.master            bus,
   output logic                           busyOut,
   output logic                           doneOut
);

   wr_state_e                 state_q, state_d;
   logic [BUS_ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_WIDTH-1:0]      n_q, n_d;
   logic [CNT_WIDTH-1:0]      wordCnt_q, wordCnt_d;
   logic [BUS_DATA_WIDTH-1:0] pack_q, pack_d;
   logic                      lane_q, lane_d;
   logic                      ready_q, ready_d;
   logic                      req_q, req_d;
   logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WE_WIDTH-1:0]   we_q, we_d;
   logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic                      start_w;
   logic                      xfer_w;
   logic                      lastElem_w;
   logic [CNT_WIDTH-1:0]      elemCnt_w;
   logic [BUS_DATA_WIDTH-1:0] packNext_w;

   assign start_w = (state_q == ST_IDLE) && startIn;
   assign xfer_w  = (state_q == ST_FILL) && bus.validIn && ready_q;

   // elemCnt counts every accepted element of the job; it is never cleared between words.
   cnn_counter u_elem_cnt (
      .clkIn    (clkIn),
      .rstIn    (rstIn),
      .clrIn    (start_w),
      .advIn    (xfer_w),
      .endValIn (n_q - CNT_WIDTH'(1)),
      .cntOut   (elemCnt_w),
      .doneOut  (lastElem_w)
   );

   assign packNext_w = lane_q ? {bus.dataIn, pack_q[DATA_WIDTH-1:0]}
                              : {pack_q[BUS_DATA_WIDTH-1:DATA_WIDTH], bus.dataIn};

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      n_d       = n_q;
      wordCnt_d = wordCnt_q;
      pack_d    = pack_q;
      lane_d    = lane_q;
      ready_d   = ready_q;
      req_d     = req_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (startIn) begin
               base_d    = baseAddrIn & ~BUS_ADDR_WIDTH'(7);
               n_d       = numResultsIn;
               wordCnt_d = '0;
               pack_d    = '0;
               lane_d    = 1'b0;
               if (numResultsIn == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FILL;
                  ready_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end

         ST_FILL: begin
            if (xfer_w) begin
               pack_d = packNext_w;
               lane_d = ~lane_q;
               // Issue the write on the accepting edge so the request is not delayed a cycle.
               if (lane_q || lastElem_w) begin
                  state_d = ST_WRITE;
                  ready_d = 1'b0;
                  req_d   = 1'b1;
                  addr_d  = word_addr(base_q, wordCnt_q);
                  wdata_d = packNext_w;
                  we_d    = lane_q ? WE_FULL : WE_LO;
               end
            end
         end

         ST_WRITE: begin
            if (req_q && bus.busAckIn) begin
               req_d     = 1'b0;
               wordCnt_d = wordCnt_q + CNT_WIDTH'(1);
               if (elemCnt_w == n_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_FILL;
                  ready_d = 1'b1;
                  pack_d  = '0;
                  lane_d  = 1'b0;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         n_q       <= '0;
         wordCnt_q <= '0;
         pack_q    <= '0;
         lane_q    <= 1'b0;
         ready_q   <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= '0;
         we_q      <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         n_q       <= n_d;
         wordCnt_q <= wordCnt_d;
         pack_q    <= pack_d;
         lane_q    <= lane_d;
         ready_q   <= ready_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.readyOut     = ready_q;
   assign bus.busReqOut    = req_q;
   assign bus.busAddrOut   = addr_q;
   assign bus.busWrEnOut   = we_q;
   assign bus.busWrDataOut = wdata_q;
   assign busyOut          = busy_q;
   assign doneOut          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_result_writer.sv
// Scoreboard bench for cnn_result_writer: jobs push expected bus writes, a monitor pops and compares.
`default_nettype none

module tb_cnn_result_writer;
   import cnn_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  we;
   } wr_t;

   logic        clkIn = 1'b0;
   logic        rstIn = 1'b0;
   logic        startIn = 1'b0;
   logic [31:0] baseAddrIn = '0;
   logic [15:0] numResultsIn = '0;
   logic        busyOut;
   logic        doneOut;

   cnn_result_writer_if bus ();

   cnn_result_writer dut (
      .clkIn        (clkIn),
      .rstIn        (rstIn),
      .startIn      (startIn),
      .baseAddrIn   (baseAddrIn),
      .numResultsIn (numResultsIn),
      .bus          (bus),
      .busyOut      (busyOut),
      .doneOut      (doneOut)
   );

   always #5 clkIn = ~clkIn;

   wr_t         expQ[$];
   logic [31:0] fifoQ[$];
   int total = 0;
   int bad = 0;
   int doneSeen = 0;
   int expDone = 0;
   int vmode = 0;
   int amode = 0;
   int ackDelay = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail_evt(input string nm);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Reference model: element pairs map to consecutive 8-byte words from the aligned base.
   task automatic build_job(input logic [31:0] base, input logic [31:0] dat[$]);
      int n;
      wr_t e;
      n = dat.size();
      foreach (dat[i]) fifoQ.push_back(dat[i]);
      for (int w = 0; w < (n + 1) / 2; w++) begin
         e.a = (base & 32'hFFFF_FFF8) + 32'(8 * w);
         if (2 * w + 1 < n) begin
            e.d  = {dat[2*w+1], dat[2*w]};
            e.we = 8'hFF;
         end else begin
            e.d  = {32'h0, dat[2*w]};
            e.we = 8'h0F;
         end
         expQ.push_back(e);
      end
      expDone++;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [15:0] n);
      @(posedge clkIn);
      #1;
      startIn = 1'b1;
      baseAddrIn = base;
      numResultsIn = n;
      @(posedge clkIn);
      #1;
      startIn = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int k;
      k = 0;
      while (doneSeen == d0 && k < limit) begin
         @(posedge clkIn);
         k++;
      end
      if (doneSeen == d0) fail_evt("done_timeout");
      @(posedge clkIn);
      #1;
      chk("writes_outstanding", 64'(expQ.size()), 64'd0);
      chk("fifo_left", 64'(fifoQ.size()), 64'd0);
   endtask

   task automatic run_job(input logic [31:0] base, input logic [31:0] dat[$],
                          input int vm, input int am, input int dly);
      int d0;
      vmode = vm;
      amode = am;
      ackDelay = dly;
      build_job(base, dat);
      d0 = doneSeen;
      pulse_start(base, 16'(dat.size()));
      wait_done(d0, 400);
   endtask

   // Stream source: presents the head of fifoQ and pops it after each accepting edge.
   initial begin : drv
      bit fire;
      bit tog;
      bit v;
      tog = 1'b0;
      bus.validIn = 1'b0;
      bus.dataIn = '0;
      forever begin
         @(negedge clkIn);
         fire = bus.validIn && bus.readyOut && rstIn;
         @(posedge clkIn);
         #1;
         if (fire && fifoQ.size() > 0) void'(fifoQ.pop_front());
         tog = ~tog;
         case (vmode)
            0:       v = 1'b1;
            1:       v = tog;
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.validIn = (fifoQ.size() > 0) && v;
         bus.dataIn = (fifoQ.size() > 0) ? fifoQ[0] : $urandom;
      end
   end

   initial begin : ackdrv
      int age;
      age = 0;
      bus.busAckIn = 1'b0;
      forever begin
         @(posedge clkIn);
         #1;
         age = bus.busReqOut ? age + 1 : 0;
         case (amode)
            0:       bus.busAckIn = 1'b1;
            1:       bus.busAckIn = 1'($urandom_range(0, 1));
            default: bus.busAckIn = (age > ackDelay);
         endcase
      end
   end

   logic mon_hold = 1'b0;
   logic mon_prevDone = 1'b0;
   wr_t  mon_prev;
   wr_t  mon_cur;
   wr_t  mon_exp;

   always @(negedge clkIn) begin
      if (!rstIn) begin
         mon_hold = 1'b0;
         mon_prevDone = 1'b0;
      end else begin
         mon_cur = {bus.busAddrOut, bus.busWrDataOut, bus.busWrEnOut};
         if (mon_hold) begin
            chk("hold_req", 64'(bus.busReqOut), 64'd1);
            chk("hold_addr", 64'(mon_cur.a), 64'(mon_prev.a));
            chk("hold_data", mon_cur.d, mon_prev.d);
            chk("hold_we", 64'(mon_cur.we), 64'(mon_prev.we));
         end
         mon_hold = 1'b0;
         if (bus.busReqOut) begin
            chk("ready_in_write", 64'(bus.readyOut), 64'd0);
            if (bus.busAckIn) begin
               if (expQ.size() == 0) begin
                  fail_evt("unexpected_write");
               end else begin
                  mon_exp = expQ.pop_front();
                  chk("wr_addr", 64'(mon_cur.a), 64'(mon_exp.a));
                  chk("wr_data", mon_cur.d, mon_exp.d);
                  chk("wr_we", 64'(mon_cur.we), 64'(mon_exp.we));
               end
            end else begin
               mon_hold = 1'b1;
               mon_prev = mon_cur;
            end
         end
         if (doneOut) begin
            doneSeen++;
            if (mon_prevDone) fail_evt("done_long");
            if (expDone == 0) fail_evt("unexpected_done");
            else expDone--;
            chk("done_busy", 64'(busyOut), 64'd0);
         end
         mon_prevDone = doneOut;
      end
   end

   initial begin : main
      logic [31:0] dat[$];
      int d0;
      int k;
      int n;

      #1;
      chk("rst_ready", 64'(bus.readyOut), 64'd0);
      chk("rst_req", 64'(bus.busReqOut), 64'd0);
      chk("rst_addr", 64'(bus.busAddrOut), 64'd0);
      chk("rst_we", 64'(bus.busWrEnOut), 64'd0);
      chk("rst_data", bus.busWrDataOut, 64'd0);
      chk("rst_busy", 64'(busyOut), 64'd0);
      chk("rst_done", 64'(doneOut), 64'd0);
      #21 rstIn = 1'b1;

      dat = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      run_job(32'h0000_1000, dat, 0, 0, 0);

      dat = '{$urandom, $urandom, $urandom};
      run_job(32'h0000_2004, dat, 0, 0, 0);

      // Zero-length job: done one cycle after the start edge, no bus traffic.
      vmode = 0;
      amode = 0;
      expDone++;
      d0 = doneSeen;
      pulse_start(32'h0000_5000, 16'd0);
      @(negedge clkIn);
      chk("n0_done", 64'(doneOut), 64'd1);
      chk("n0_req", 64'(bus.busReqOut), 64'd0);
      wait_done(d0, 20);

      dat = '{$urandom, $urandom};
      run_job(32'h0000_4000, dat, 0, 2, 5);

      dat = '{$urandom};
      run_job(32'h0000_6010, dat, 2, 1, 0);

      dat = '{$urandom, $urandom, $urandom, $urandom};
      run_job(32'hFFFF_FFF8, dat, 0, 0, 0);

      // N=6 with toggling valid and an ignored start while busy.
      dat = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      vmode = 1;
      amode = 0;
      build_job(32'h0000_7000, dat);
      d0 = doneSeen;
      pulse_start(32'h0000_7000, 16'd6);
      repeat (3) @(posedge clkIn);
      #1;
      chk("busy_midjob", 64'(busyOut), 64'd1);
      pulse_start(32'h0000_9000, 16'd2);
      wait_done(d0, 400);

      // Reset while a write request is pending.
      vmode = 0;
      amode = 2;
      ackDelay = 50;
      dat = '{$urandom, $urandom, $urandom, $urandom};
      build_job(32'h0000_3000, dat);
      d0 = doneSeen;
      pulse_start(32'h0000_3000, 16'd4);
      k = 0;
      while (!bus.busReqOut && k < 50) begin
         @(negedge clkIn);
         k++;
      end
      chk("rst_mid_req_seen", 64'(bus.busReqOut), 64'd1);
      #2 rstIn = 1'b0;
      #1;
      chk("rstmid_ready", 64'(bus.readyOut), 64'd0);
      chk("rstmid_req", 64'(bus.busReqOut), 64'd0);
      chk("rstmid_addr", 64'(bus.busAddrOut), 64'd0);
      chk("rstmid_we", 64'(bus.busWrEnOut), 64'd0);
      chk("rstmid_data", bus.busWrDataOut, 64'd0);
      chk("rstmid_busy", 64'(busyOut), 64'd0);
      @(posedge clkIn);
      #2;
      fifoQ.delete();
      expQ.delete();
      expDone = 0;
      repeat (2) @(posedge clkIn);
      @(negedge clkIn);
      #2 rstIn = 1'b1;
      repeat (10) @(posedge clkIn);
      chk("no_done_after_reset", 64'(doneSeen), 64'(d0));
      dat = '{$urandom, $urandom, $urandom};
      run_job(32'h0000_3000, dat, 0, 0, 0);

      for (int j = 0; j < 15; j++) begin
         n = $urandom_range(0, 9);
         dat.delete();
         for (int i = 0; i < n; i++) dat.push_back($urandom);
         run_job($urandom, dat, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      chk("done_balance", 64'(expDone), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
